// File: rtl/dda_feed_pkg.sv
// -----------------------------------------------------------------------------
// dda_feed_pkg
// Shared types and constants for the DDA command feeder.
//   NMAX1      : largest pulse count the DDA can emit in one period
//   CMD_STOP   : zero-velocity command issued when the buffer runs dry
//   dda_cmd_t  : command word, dir in bit 7, magnitude in bits 6:0
//   feed_state_t : IDLE / COUNT / ISSUE period-sequencer states
// -----------------------------------------------------------------------------
package dda_feed_pkg;

    localparam int         NMAX1    = 49;
    localparam logic [7:0] CMD_STOP = 8'h00;

    typedef struct packed {
        logic       dir;
        logic [6:0] mag;
    } dda_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ISSUE = 2'd2
    } feed_state_t;

    // Saturate the magnitude to what the DDA can physically produce;
    // direction passes through untouched.
    function automatic dda_cmd_t clamp_cmd(input dda_cmd_t cmd);
        dda_cmd_t res;
        res = cmd;
        if (cmd.mag > 7'(NMAX1)) begin
            res.mag = 7'(NMAX1);
        end
        return res;
    endfunction

endpackage

// File: rtl/dda_cmd_fifo.sv
// -----------------------------------------------------------------------------
// dda_cmd_fifo
// Synchronous FIFO holding host step commands until the period tick pops them.
// The caller is responsible for qualifying i_push / i_pop (no push into a full
// FIFO unless a pop happens in the same cycle, no pop from an empty FIFO).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata at the tail this cycle
//   i_pop      : advance the head this cycle
//   i_wdata    : word to write
//   o_rdata    : head word (combinational, valid when not empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_level    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module dda_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // differing only in the wrap bit mean full.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Head is read before the edge, so a push into the slot being popped
    // (full FIFO, simultaneous push/pop) cannot corrupt the outgoing word.
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (o_level == (AW+1)'(DEPTH));

endmodule

// File: rtl/dda_cmd_feeder.sv
// -----------------------------------------------------------------------------
// dda_cmd_feeder
// Buffers host step commands and issues exactly one command to the DDA every
// PERIOD_CYC clocks, substituting a stop command when the buffer is empty.
//   clk, rst_n   : clock, asynchronous active-low reset
//   host_data    : command word from host (bit7 dir, bits 6:0 pulses)
//   host_we      : one-cycle push strobe
//   enable       : runs the period timer while high
//   clr_flags    : one-cycle clear of sticky flags (a same-cycle set wins)
//   dda_busy     : DDA still working on the previous command
//   dda_n        : registered command word to the DDA
//   dda_wr       : registered load strobe, WR_PULSE_CYC cycles wide
//   fifo_full / fifo_empty / fifo_level : buffer status
//   underrun     : sticky, a period was issued from an empty buffer
//   overflow     : sticky, a push was dropped on a full buffer
//   late         : sticky, dda_busy was high at an issue tick
// Build option: define DDA_FEED_CLAMP_EN to saturate magnitudes to NMAX1.
// -----------------------------------------------------------------------------
module dda_cmd_feeder
    import dda_feed_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int PERIOD_CYC   = 20000,
    parameter int WR_PULSE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             host_data,
    input  logic                   host_we,
    input  logic                   enable,
    input  logic                   clr_flags,
    input  logic                   dda_busy,
    output logic [7:0]             dda_n,
    output logic                   dda_wr,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underrun,
    output logic                   overflow,
    output logic                   late
);

    localparam int TW = $clog2(PERIOD_CYC);

    feed_state_t r_state;
    feed_state_t w_state_next;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_pulse_cnt;
    logic [2:0]    w_pulse_next;
    logic [7:0]    r_dda_n;
    logic          r_dda_wr;
    logic          r_underrun;
    logic          r_overflow;
    logic          r_late;

    logic          w_tick;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_fifo_rdata;
    dda_cmd_t      w_head;
    dda_cmd_t      w_head_fwd;
    dda_cmd_t      w_cmd_next;

    dda_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (host_data),
        .o_rdata (w_fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (fifo_level)
    );

    // The timer runs whenever enable is high, independent of the FSM state,
    // so the tick spacing is exactly PERIOD_CYC even across the ISSUE phase.
    assign w_tick = enable && (r_timer == TW'(PERIOD_CYC - 1));
    assign w_pop  = w_tick && !fifo_empty;
    // A full FIFO still accepts a push when the tick frees a slot this cycle.
    assign w_push = host_we && (!fifo_full || w_pop);

    assign w_head = dda_cmd_t'(w_fifo_rdata);
`ifdef DDA_FEED_CLAMP_EN
    assign w_head_fwd = clamp_cmd(w_head);
`else
    assign w_head_fwd = w_head;
`endif
    assign w_cmd_next = fifo_empty ? dda_cmd_t'(CMD_STOP) : w_head_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!enable || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pulse_next = r_pulse_cnt;
        case (r_state)
            IDLE: begin
                w_pulse_next = '0;
                if (enable) w_state_next = COUNT;
            end
            COUNT: begin
                w_pulse_next = '0;
                if (w_tick) w_state_next = ISSUE;
            end
            ISSUE: begin
                if (r_pulse_cnt == 3'(WR_PULSE_CYC - 1)) begin
                    w_state_next = COUNT;
                    w_pulse_next = '0;
                end else begin
                    w_pulse_next = r_pulse_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (!enable) w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pulse_cnt <= '0;
            r_dda_wr    <= 1'b0;
            r_dda_n     <= CMD_STOP;
        end else begin
            r_state     <= w_state_next;
            r_pulse_cnt <= w_pulse_next;
            // Strobe is high exactly while the FSM sits in ISSUE.
            r_dda_wr    <= (w_state_next == ISSUE);
            if (w_tick) r_dda_n <= w_cmd_next;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
        end else begin
            if (w_tick && fifo_empty)                 r_underrun <= 1'b1;
            else if (clr_flags)                       r_underrun <= 1'b0;
            if (host_we && fifo_full && !w_pop)       r_overflow <= 1'b1;
            else if (clr_flags)                       r_overflow <= 1'b0;
            if (w_tick && dda_busy)                   r_late     <= 1'b1;
            else if (clr_flags)                       r_late     <= 1'b0;
        end
    end

    assign dda_n    = r_dda_n;
    assign dda_wr   = r_dda_wr;
    assign underrun = r_underrun;
    assign overflow = r_overflow;
    assign late     = r_late;

endmodule

// File: tb/tb_dda_cmd_feeder.sv
// -----------------------------------------------------------------------------
// tb_dda_cmd_feeder
// Directed bench for dda_cmd_feeder with PERIOD_CYC=20, DEPTH=4, WR_PULSE_CYC=2.
// A reference queue models the FIFO contents; every rising dda_wr pops the
// expected command (or the stop word when the model is empty) and compares.
// -----------------------------------------------------------------------------
module tb_dda_cmd_feeder;

    localparam int P = 20;
    localparam int D = 4;
    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_we = 1'b0;
    logic       enable = 1'b0;
    logic       clr_flags = 1'b0;
    logic       dda_busy = 1'b0;
    logic [7:0] dda_n;
    logic       dda_wr;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_level;
    logic       underrun;
    logic       overflow;
    logic       late;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] mdl[$];
    logic [7:0] sb_exp;
    logic       prev_wr = 1'b0;

    dda_cmd_feeder #(
        .DEPTH        (D),
        .PERIOD_CYC   (P),
        .WR_PULSE_CYC (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_data  (host_data),
        .host_we    (host_we),
        .enable     (enable),
        .clr_flags  (clr_flags),
        .dda_busy   (dda_busy),
        .dda_n      (dda_n),
        .dda_wr     (dda_wr),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .overflow   (overflow),
        .late       (late)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cmd(input logic [7:0] w);
`ifdef DDA_FEED_CLAMP_EN
        if (w[6:0] > 7'd49) return {w[7], 7'd49};
`endif
        return w;
    endfunction

    // Advance to just after the rising edge that starts cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic next_cycle();
        goto(cyc + 1);
    endtask

    task automatic sample_at(input int c);
        goto(c);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        host_data = d;
        host_we   = 1'b1;
        if (accept) mdl.push_back(exp_cmd(d));
        next_cycle();
        host_we   = 1'b0;
    endtask

    // Scoreboard: each new strobe must carry the oldest modelled command.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 1'b0;
        end else begin
            if (dda_wr && !prev_wr) begin
                sb_exp = (mdl.size() > 0) ? mdl.pop_front() : 8'h00;
                chk("sb_cmd", dda_n, sb_exp);
            end
            prev_wr = dda_wr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int strobes;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_dda_n", dda_n, 8'h00);
        chk("rst_dda_wr", dda_wr, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_flags", {underrun, overflow, late}, 3'b000);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---------------- steady feed ----------------
        push(8'h05, 1'b1);
        @(negedge clk);
        chk("feed_lvl1", fifo_level, 3'd1);
        next_cycle();
        push(8'h85, 1'b1);
        @(negedge clk);
        chk("feed_lvl2", fifo_level, 3'd2);
        next_cycle();
        k = cyc;
        enable = 1'b1;
        sample_at(k + P - 1);
        chk("feed_pre_wr", dda_wr, 1'b0);
        sample_at(k + P);
        chk("feed1_wr", dda_wr, 1'b1);
        chk("feed1_n", dda_n, 8'h05);
        sample_at(k + P + 1);
        chk("feed1_wr_w2", dda_wr, 1'b1);
        sample_at(k + P + 2);
        chk("feed1_wr_end", dda_wr, 1'b0);
        sample_at(k + 2 * P);
        chk("feed2_wr", dda_wr, 1'b1);
        chk("feed2_n", dda_n, 8'h85);
        chk("feed2_empty", fifo_empty, 1'b1);
        sample_at(k + 2 * P + 1);
        chk("feed2_n_hold", dda_n, 8'h85);

        // ---------------- underrun ----------------
        sample_at(k + 3 * P - 1);
        chk("unr_pre", underrun, 1'b0);
        sample_at(k + 3 * P);
        chk("unr_wr", dda_wr, 1'b1);
        chk("unr_n", dda_n, 8'h00);
        chk("unr_flag", underrun, 1'b1);
        goto(k + 3 * P + 3);
        clr_flags = 1'b1;
        next_cycle();
        clr_flags = 1'b0;
        @(negedge clk);
        chk("unr_clr", underrun, 1'b0);
        next_cycle();
        enable = 1'b0;
        next_cycle();

        // ---------------- overflow and concurrency ----------------
        push(8'h10, 1'b1);
        push(8'h31, 1'b1);
        push(8'hB2, 1'b1);
        push(8'h7F, 1'b1);
        push(8'h22, 1'b0);
        @(negedge clk);
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_level", fifo_level, 3'd4);
        next_cycle();
        clr_flags = 1'b1;
        next_cycle();
        clr_flags = 1'b0;
        @(negedge clk);
        chk("ovf_clr", {underrun, overflow, late}, 3'b000);
        next_cycle();
        k = cyc;
        enable = 1'b1;
        goto(k + P - 1);
        host_data = 8'hFF;
        host_we   = 1'b1;
        mdl.push_back(exp_cmd(8'hFF));
        @(negedge clk);
        chk("conc_pre_full", fifo_full, 1'b1);
        next_cycle();
        host_we = 1'b0;
        @(negedge clk);
        chk("conc_level", fifo_level, 3'd4);
        chk("conc_no_ovf", overflow, 1'b0);
        chk("conc_wr", dda_wr, 1'b1);
        chk("conc_n", dda_n, 8'h10);
        for (int i = 1; i <= 5; i++) begin
            sample_at(k + P + i * P);
            chk("drain_wr", dda_wr, 1'b1);
        end
        chk("drain_unr_n", dda_n, 8'h00);
        chk("drain_unr_flag", underrun, 1'b1);

        // ---------------- late and enable drop ----------------
        goto(k + 7 * P - 5);
        dda_busy = 1'b1;
        sample_at(k + 7 * P - 1);
        chk("late_pre", late, 1'b0);
        sample_at(k + 7 * P);
        chk("late_flag", late, 1'b1);
        chk("late_wr", dda_wr, 1'b1);
        next_cycle();
        enable   = 1'b0;
        dda_busy = 1'b0;
        @(negedge clk);
        chk("drop_wr_hold", dda_wr, 1'b1);
        sample_at(k + 7 * P + 2);
        chk("drop_wr_low", dda_wr, 1'b0);
        strobes = 0;
        repeat (3 * P) begin
            next_cycle();
            @(negedge clk);
            if (dda_wr) strobes++;
        end
        chk("drop_no_strobe", strobes, 0);

        // ---------------- asynchronous reset mid-ISSUE ----------------
        next_cycle();
        push(8'h85, 1'b1);
        push(8'h03, 1'b1);
        k = cyc;
        enable = 1'b1;
        sample_at(k + P);
        chk("ar_pre_wr", dda_wr, 1'b1);
        chk("ar_pre_n", dda_n, 8'h85);
        chk("ar_pre_level", fifo_level, 3'd1);
        chk("ar_pre_late", late, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wr", dda_wr, 1'b0);
        chk("ar_n", dda_n, 8'h00);
        chk("ar_level", fifo_level, 3'd0);
        chk("ar_empty", fifo_empty, 1'b1);
        chk("ar_flags", {underrun, overflow, late}, 3'b000);
        mdl.delete();
        enable = 1'b0;
        #20;
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
